pacman_map_writer: RTL and testbench
====================================

Name: pacman_map_writer

Overview:
- Map-RAM write engine on the responder side of the pacman move handshake.
- On a move request it reads the target tile, then erases pacman at the current tile and draws pacman at the next tile.
- It counts eaten pills, reports blocked moves, and ends every request with a one-cycle done pulse.
- Sits between the location controller (which supplies curr/next coordinates and consumes done) and the single-port synchronous tile RAM that the VGA renderer also reads.

Parameters:
- MAP_W, 40, map width in tiles.
- MAP_H, 30, map height in tiles.
- ADDR_W, 11, tile RAM address width; must satisfy 2^ADDR_W >= MAP_W*MAP_H.
- PILL_W, 33, pill counter width.
- POWER_TICKS, 24'd5000000, power-mode duration in clocks (used only with the optional feature).

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  1  move request; sampled only in IDLE.
- curr_x  in  6  current pacman tile x.
- curr_y  in  5  current pacman tile y.
- next_x  in  6  requested tile x.
- next_y  in  5  requested tile y.
- ram_addr  out  ADDR_W  tile RAM address, y*MAP_W + x.
- ram_wr_en  out  1  tile RAM write enable.
- ram_wr_data  out  4  tile code to write.
- ram_rd_data  in  4  tile code; valid the cycle after the address is presented.
- done  out  1  one-cycle completion pulse.
- blocked  out  1  qualifies done: the move was rejected.
- pill_count  out  PILL_W  pills eaten since reset.
- power_active  out  1  power mode active (optional feature).

Behaviour:
- Tile codes: 0 EMPTY, 1 WALL, 2 PILL, 3 POWER_PILL, 4 PACMAN; all other codes are treated as EMPTY.
- Reset values: state IDLE; ram_addr 0, ram_wr_en 0, ram_wr_data 0, done 0, blocked 0, pill_count 0, power_active 0.
- All outputs are registered.
- State machine:
  - IDLE: when req=1, latch curr/next coordinates and go to RD. req in any other state is ignored; no queuing.
  - RD: ram_addr = next address; ram_wr_en 0. Go to RD_WAIT.
  - RD_WAIT: capture ram_rd_data into tile_q.
    - If tile_q = WALL, or next_x >= MAP_W, or next_y >= MAP_H: go to FIN with blocked set.
    - Else if next == curr: go to DRAW (skip the erase).
    - Else go to ERASE.
  - ERASE: ram_addr = curr address, ram_wr_data = EMPTY, ram_wr_en 1. Go to DRAW.
  - DRAW: ram_addr = next address, ram_wr_data = PACMAN, ram_wr_en 1.
    - pill_count increments by 1 if tile_q is PILL or POWER_PILL.
    - Go to FIN.
  - FIN: done = 1 for exactly one cycle; blocked holds its value from this request. Go to IDLE.
  - blocked clears on the next accepted req.
- Latency: with req sampled high at edge k, done is high during cycle k+5 for a normal move, k+4 for a blocked move, and k+4 when next == curr.
- A blocked request performs zero RAM writes; ram_wr_en is never high.
- Out-of-range coordinates: the RD read address is still computed, but the result is ignored. No address outside 0..MAP_W*MAP_H-1 is ever written.
- pill_count wraps modulo 2^PILL_W.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; a partially completed erase/draw is not rolled back.
- ram_wr_en is high only in ERASE and DRAW.

Optional Feature:
- Macro: PACMAN_POWER_PILL_EN.
- Defined:
  - A POWER_PILL eaten in DRAW loads a 24-bit timer with POWER_TICKS and sets power_active.
  - The timer decrements every clock; power_active clears when it reaches 0.
  - A second power pill while active reloads the timer.
- Not defined: POWER_PILL is counted as an ordinary pill, and power_active is tied 0.

Test Plan:
- Reset, then req with curr=(20,20), next=(20,19), RAM tile=EMPTY -> writes EMPTY@820, then PACMAN@780; done 5 cycles after req; blocked 0; pill_count 0.
- next=(21,20) with tile=PILL -> writes @820 and @821; pill_count 1; done pulse exactly one cycle.
- next=(19,20) with tile=WALL -> no ram_wr_en; done with blocked=1 at k+4; pill_count unchanged.
- next=(45,20) (x >= MAP_W) -> blocked=1; no writes; next req with a valid move clears blocked.
- req held high continuously for 12 cycles -> exactly two completions, each with a single-cycle done; req toggled during RD..FIN is ignored.
- Reset asserted during ERASE -> ram_wr_en 0 and done 0 immediately, state IDLE; with PACMAN_POWER_PILL_EN, a POWER_PILL tile sets power_active for POWER_TICKS cycles, then clears.

Source files
------------

// File: rtl/pacman_map_writer.sv
// pacman_map_writer
// -----------------
// Tile-RAM write engine on the responder side of the pacman move handshake.
// For each accepted move request it reads the target tile and decides whether
// the move is legal. If it is, it erases pacman from the current tile and
// draws pacman on the next tile. It counts eaten pills and finishes every
// request with a one-cycle done pulse. blocked qualifies that pulse.
//
// Optional feature: define PACMAN_POWER_PILL_EN to build the power-mode
// timer. When the macro is undefined, power_active is tied low and a power
// pill counts as an ordinary pill.
//
// All outputs come straight from flops. Each output register is loaded from
// the next state, so it changes on the same edge as the state it belongs to.

module pacman_map_writer #(
  parameter int          MAP_W       = 40,
  parameter int          MAP_H       = 30,
  parameter int          ADDR_W      = 11,
  parameter int          PILL_W      = 33,
  parameter logic [23:0] POWER_TICKS = 24'd5000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req,
  input  logic [5:0]        curr_x,
  input  logic [4:0]        curr_y,
  input  logic [5:0]        next_x,
  input  logic [4:0]        next_y,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic [3:0]        ram_wr_data,
  input  logic [3:0]        ram_rd_data,
  output logic              done,
  output logic              blocked,
  output logic [PILL_W-1:0] pill_count,
  output logic              power_active
);

  // Tile codes. Codes above PACMAN carry no meaning and behave like EMPTY.
  localparam logic [3:0] TILE_EMPTY  = 4'd0;
  localparam logic [3:0] TILE_WALL   = 4'd1;
  localparam logic [3:0] TILE_PILL   = 4'd2;
  localparam logic [3:0] TILE_POWER  = 4'd3;
  localparam logic [3:0] TILE_PACMAN = 4'd4;

  // State sequence for one request:
  //   RD      - the target address is on the RAM port.
  //   RD_WAIT - the RAM returns the tile, and it is captured.
  //   DECIDE  - the move is judged from the registered tile and coordinates.
  //   ERASE   - EMPTY is written at the current tile.
  //   DRAW    - PACMAN is written at the next tile.
  //   REJECT  - one idle slot for a refused move. It gives a blocked move the
  //             same completion latency as a same-tile move.
  //   FIN     - done pulse.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_DECIDE,
    S_ERASE,
    S_DRAW,
    S_REJECT,
    S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          cx_q, cx_d, nx_q, nx_d;
  logic [4:0]          cy_q, cy_d, ny_q, ny_d;
  logic [3:0]          tile_q, tile_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_wr_en_q, ram_wr_en_d;
  logic [3:0]          ram_wr_data_q, ram_wr_data_d;
  logic                done_q, done_d;
  logic                blocked_q, blocked_d;
  logic [PILL_W-1:0]   pill_q, pill_d;

`ifdef PACMAN_POWER_PILL_EN
  logic [23:0]         timer_q, timer_d;
  logic                power_q, power_d;
`endif

  // Linear tile address y*MAP_W + x. Any 6-bit x and 5-bit y fit in ADDR_W
  // bits, so out-of-range reads still form a real address. The read result
  // is simply ignored in that case.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [5:0] x,
                                                  input logic [4:0] y);
    return ADDR_W'(y) * ADDR_W'(MAP_W) + ADDR_W'(x);
  endfunction

  function automatic logic in_map(input logic [5:0] x, input logic [4:0] y);
    return (int'(x) < MAP_W) && (int'(y) < MAP_H);
  endfunction

  function automatic logic is_pill(input logic [3:0] t);
    return (t == TILE_PILL) || (t == TILE_POWER);
  endfunction

  // Next-state logic and next values of every output register.
  // NOTE: every variable gets a default before the case statement. Any path
  // that does not assign a variable then holds its value instead of
  // inferring a latch.
  always_comb begin
    state_d       = state_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    nx_d          = nx_q;
    ny_d          = ny_q;
    tile_d        = tile_q;
    blocked_d     = blocked_q;
    pill_d        = pill_q;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          cx_d      = curr_x;
          cy_d      = curr_y;
          nx_d      = next_x;
          ny_d      = next_y;
          blocked_d = 1'b0;
          state_d   = S_RD;
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        tile_d  = ram_rd_data;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        // The current tile is range-checked as well, so the erase can never
        // write outside the map.
        if ((tile_q == TILE_WALL) || !in_map(nx_q, ny_q) || !in_map(cx_q, cy_q)) begin
          blocked_d = 1'b1;
          state_d   = S_REJECT;
        end else if ((nx_q == cx_q) && (ny_q == cy_q)) begin
          state_d = S_DRAW;
        end else begin
          state_d = S_ERASE;
        end
      end
      S_ERASE:  state_d = S_DRAW;
      S_DRAW:   state_d = S_FIN;
      S_REJECT: state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Output registers follow the state being entered.
    ram_wr_en_d = (state_d == S_ERASE) || (state_d == S_DRAW);
    done_d      = (state_d == S_FIN);

    case (state_d)
      S_RD: ram_addr_d = tile_addr(nx_d, ny_d);
      S_ERASE: begin
        ram_addr_d    = tile_addr(cx_d, cy_d);
        ram_wr_data_d = TILE_EMPTY;
      end
      S_DRAW: begin
        ram_addr_d    = tile_addr(nx_d, ny_d);
        ram_wr_data_d = TILE_PACMAN;
      end
      default: ;
    endcase

    // DRAW lasts one cycle, so entering it counts each eaten pill exactly
    // once. The counter wraps naturally.
    if ((state_d == S_DRAW) && is_pill(tile_q)) begin
      pill_d = pill_q + PILL_W'(1);
    end

`ifdef PACMAN_POWER_PILL_EN
    // A power pill (re)loads the timer. Otherwise the timer counts down, and
    // power mode ends on the cycle the timer reaches zero.
    timer_d = timer_q;
    power_d = power_q;
    if ((state_d == S_DRAW) && (tile_q == TILE_POWER)) begin
      timer_d = POWER_TICKS;
      power_d = (POWER_TICKS != 24'd0);
    end else if (timer_q != 24'd0) begin
      timer_d = timer_q - 24'd1;
      if (timer_q == 24'd1) begin
        power_d = 1'b0;
      end
    end
`endif
  end

  // State and output registers. Reset returns everything to idle at once.
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample their inputs on the same edge, whatever order the statements
  // appear in.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cx_q          <= '0;
      cy_q          <= '0;
      nx_q          <= '0;
      ny_q          <= '0;
      tile_q        <= TILE_EMPTY;
      ram_addr_q    <= '0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_data_q <= '0;
      done_q        <= 1'b0;
      blocked_q     <= 1'b0;
      pill_q        <= '0;
`ifdef PACMAN_POWER_PILL_EN
      timer_q       <= '0;
      power_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      nx_q          <= nx_d;
      ny_q          <= ny_d;
      tile_q        <= tile_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_data_q <= ram_wr_data_d;
      done_q        <= done_d;
      blocked_q     <= blocked_d;
      pill_q        <= pill_d;
`ifdef PACMAN_POWER_PILL_EN
      timer_q       <= timer_d;
      power_q       <= power_d;
`endif
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_data = ram_wr_data_q;
  assign done        = done_q;
  assign blocked     = blocked_q;
  assign pill_count  = pill_q;

`ifdef PACMAN_POWER_PILL_EN
  assign power_active = power_q;
`else
  // Power mode is not built, so the output is constant zero. POWER_TICKS
  // appears here only so the parameter stays referenced.
  assign power_active = 1'b0 && (POWER_TICKS != 24'd0);
`endif

endmodule

// File: tb/tb_pacman_map_writer.sv
// Self-checking bench for pacman_map_writer.
// The bench models the tile RAM (a synchronous read of a single target tile).
// Expected RAM writes and done events are queued when a request is driven.
// A negedge monitor pops and compares them as the design produces them.
`timescale 1ns/1ps

module tb_pacman_map_writer;

  localparam int          MAP_W  = 40;
  localparam int          MAP_H  = 30;
  localparam int          ADDR_W = 11;
  localparam int          PILL_W = 33;
  localparam logic [23:0] TICKS  = 24'd16;

  logic              CLOCK_50 = 1'b0;
  logic              reset    = 1'b1;
  logic              req      = 1'b0;
  logic [5:0]        curr_x   = '0;
  logic [4:0]        curr_y   = '0;
  logic [5:0]        next_x   = '0;
  logic [4:0]        next_y   = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr_en;
  logic [3:0]        ram_wr_data;
  logic [3:0]        ram_rd_data;
  logic              done;
  logic              blocked;
  logic [PILL_W-1:0] pill_count;
  logic              power_active;

  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc      = 0;
  logic [PILL_W-1:0] model_pills = '0;
  logic [ADDR_W-1:0] tgt_addr = '0;
  logic [3:0]        tgt_tile = '0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        data;
  } wr_t;

  typedef struct {
    int                done_cyc;
    logic              blk;
    logic [PILL_W-1:0] pills;
  } exp_t;

  wr_t  wr_q[$];
  exp_t exp_q[$];

  pacman_map_writer #(.POWER_TICKS(TICKS)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .req         (req),
    .curr_x      (curr_x),
    .curr_y      (curr_y),
    .next_x      (next_x),
    .next_y      (next_y),
    .ram_addr    (ram_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data),
    .done        (done),
    .blocked     (blocked),
    .pill_count  (pill_count),
    .power_active(power_active)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Edge counter and tile RAM: the target tile reads back as the tile chosen
  // by the test, and every other address reads as EMPTY.
  always @(posedge CLOCK_50) begin
    cyc         <= cyc + 1;
    ram_rd_data <= (ram_addr == tgt_addr) ? tgt_tile : 4'd0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] addr_of(input int x, input int y);
    return ADDR_W'(y * MAP_W + x);
  endfunction

  // Reference model of one accepted request that starts at edge k.
  task automatic expect_move(input int cx, input int cy, input int nx, input int ny,
                             input logic [3:0] tile, input int k);
    logic blk;
    logic same;
    int   lat;
    blk  = (tile == 4'd1) || (nx >= MAP_W) || (ny >= MAP_H);
    same = (nx == cx) && (ny == cy);
    if (!blk) begin
      if (!same) wr_q.push_back('{addr: addr_of(cx, cy), data: 4'd0});
      wr_q.push_back('{addr: addr_of(nx, ny), data: 4'd4});
      if ((tile == 4'd2) || (tile == 4'd3)) model_pills = model_pills + 1'b1;
    end
    lat = (blk || same) ? 4 : 5;
    exp_q.push_back('{done_cyc: k + lat, blk: blk, pills: model_pills});
  endtask

  task automatic drive(input int cx, input int cy, input int nx, input int ny,
                       input logic [3:0] tile);
    curr_x   = 6'(cx);
    curr_y   = 5'(cy);
    next_x   = 6'(nx);
    next_y   = 5'(ny);
    tgt_addr = addr_of(nx, ny);
    tgt_tile = tile;
  endtask

  // Raises req for one cycle. Returns at the negedge after the accepting edge.
  task automatic launch(input int cx, input int cy, input int nx, input int ny,
                        input logic [3:0] tile);
    @(negedge CLOCK_50);
    drive(cx, cy, nx, ny, tile);
    req = 1'b1;
    expect_move(cx, cy, nx, ny, tile, cyc + 1);
    @(negedge CLOCK_50);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check("done_timeout", 64'(exp_q.size()), 64'(0));
    check("wr_missing", 64'(wr_q.size()), 64'(0));
  endtask

  // Monitor: compares every RAM write and every done pulse with the queues.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (ram_wr_en) begin
        check("wr_pending", 64'(ram_wr_en), 64'(wr_q.size() != 0));
        if (wr_q.size() != 0) begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", 64'(ram_addr), 64'(w.addr));
          check("wr_data", 64'(ram_wr_data), 64'(w.data));
        end
      end
      if (done) begin
        check("done_pending", 64'(done), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("blocked", 64'(blocked), 64'(e.blk));
          check("pill_count", 64'(pill_count), 64'(e.pills));
          check("wr_en_at_done", 64'(ram_wr_en), 64'(0));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pcnt;

    // Reset state.
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    check("rst_addr", 64'(ram_addr), 64'(0));
    check("rst_wr_en", 64'(ram_wr_en), 64'(0));
    check("rst_wr_data", 64'(ram_wr_data), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_blocked", 64'(blocked), 64'(0));
    check("rst_pills", 64'(pill_count), 64'(0));
    check("rst_power", 64'(power_active), 64'(0));

    // Normal move onto an EMPTY tile: EMPTY@820, then PACMAN@780.
    launch(20, 20, 20, 19, 4'd0); wait_idle();
    // Eat a pill: writes @820 and @821.
    launch(20, 20, 21, 20, 4'd2); wait_idle();
    // Wall: no writes, blocked at k+4.
    launch(20, 20, 19, 20, 4'd1); wait_idle();
    // x beyond the map: blocked. The next valid move clears blocked.
    launch(20, 20, 45, 20, 4'd0); wait_idle();
    launch(20, 20, 20, 21, 4'd0); wait_idle();
    // y beyond the map.
    launch(3, 3, 3, 30, 4'd2); wait_idle();
    // Same tile: no erase, done at k+4, the pill still counts.
    launch(5, 5, 5, 5, 4'd2); wait_idle();

    // req held high for 12 cycles: acceptances at k and k+7 only.
    @(negedge CLOCK_50);
    drive(10, 10, 11, 10, 4'd0);
    req = 1'b1;
    k = cyc + 1;
    expect_move(10, 10, 11, 10, 4'd0, k);
    expect_move(10, 10, 11, 10, 4'd0, k + 7);
    repeat (12) @(negedge CLOCK_50);
    req = 1'b0;
    wait_idle();

    // req toggling while busy is ignored.
    @(negedge CLOCK_50);
    drive(11, 10, 11, 11, 4'd2);
    req = 1'b1;
    expect_move(11, 10, 11, 11, 4'd2, cyc + 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      req = (i % 2 == 1);
    end
    @(negedge CLOCK_50);
    req = 1'b0;
    wait_idle();

    // Reset asserted during ERASE.
    @(negedge CLOCK_50);
    drive(8, 8, 9, 8, 4'd0);
    req = 1'b1;
    @(negedge CLOCK_50);
    req = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("erase_wr_en", 64'(ram_wr_en), 64'(1));
    check("erase_addr", 64'(ram_addr), 64'(addr_of(8, 8)));
    reset = 1'b1;
    #1;
    check("mid_rst_wr_en", 64'(ram_wr_en), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_pills", 64'(pill_count), 64'(0));
    model_pills = '0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    // The engine must be idle and accept a fresh move.
    launch(12, 3, 12, 4, 4'd2); wait_idle();

    // Power pill: counted as a pill in both builds.
    launch(12, 4, 13, 4, 4'd3);
`ifdef PACMAN_POWER_PILL_EN
    pcnt = 0;
    repeat (40) begin
      @(negedge CLOCK_50);
      if (power_active) pcnt++;
    end
    check("power_cycles", 64'(pcnt), 64'(TICKS));
    wait_idle();
`else
    pcnt = 0;
    wait_idle();
    check("power_off", 64'(power_active), 64'(pcnt));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
